// File: rtl/disp_src_mux_pkg.sv
// Shared FSM encoding, select legality check and default background for the display-source mux.
package disp_pkg;

  typedef enum logic [1:0] {
    S_PROC = 2'd0,
    S_WAIT = 2'd1,
    S_DISP = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_BG = 8'hFF;

  // Index num_src is only meaningful when the internal test pattern is built.
  function automatic logic sel_legal(input int sel, input int num_src, input logic pattern_en);
    return (sel < num_src) || (pattern_en && (sel == num_src));
  endfunction

endpackage

// File: rtl/disp_src_mux_if.sv
// Display-side read bundle: address/valid from the VGA generator, pixel/valid back to it.
interface disp_src_mux_if #(
  parameter int ADDR_W = 18,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_addr_vld;
  logic [PIX_W-1:0]  pix_out;
  logic              pix_vld;

  modport master (output vga_addr, output vga_addr_vld, input pix_out, input pix_vld);
  modport slave  (input vga_addr, input vga_addr_vld, output pix_out, output pix_vld);
endinterface

// File: rtl/disp_src_mux_lat_pipe.sv
// Fixed-depth shift line for {vld, payload}; output appears DEPTH cycles after input.
// A synchronous flush clears every valid bit (including the one being loaded) in one edge.
module disp_lat_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         sh_vld,
  input  logic [W-1:0] sh_dat,
  output logic         dly_vld,
  output logic [W-1:0] dly_dat
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= sh_vld & ~flush;
      dat_q[0] <= sh_dat;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1] & ~flush;
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign dly_vld = vld_q[DEPTH-1];
  assign dly_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/disp_src_mux.sv
// Routes BRAM address buses to the engine or the display and returns display pixels 1+RD_LAT cycles later.
// Source switches only at frame_start; DISP_SRC_MUX_TEST_PATTERN_EN adds an address-XOR pattern as source NUM_SRC.
module disp_src_mux
  import disp_pkg::*;
#(
  parameter int               NUM_SRC = 2,
  parameter int               ADDR_W  = 18,
  parameter int               PIX_W   = 8,
  parameter int               RD_LAT  = 1,
  parameter logic [PIX_W-1:0] BG_PIX  = {PIX_W{1'b1}},
  parameter int               SEL_W   = $clog2(NUM_SRC + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      proc_ready,
  input  logic                      frame_start,
  input  logic [SEL_W-1:0]          sel_req,
  disp_src_mux_if.slave             vga,
  input  logic [NUM_SRC*ADDR_W-1:0] proc_addr,
  output logic [NUM_SRC*ADDR_W-1:0] buf_addr,
  input  logic [NUM_SRC*PIX_W-1:0]  buf_dout,
  output logic [SEL_W-1:0]          sel_active,
  output logic                      busy
);

`ifdef DISP_SRC_MUX_TEST_PATTERN_EN
  localparam logic PAT_EN = 1'b1;
  localparam int   PAY_W  = SEL_W + PIX_W;
`else
  localparam logic PAT_EN = 1'b0;
  localparam int   PAY_W  = SEL_W;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             req_legal;
  logic             disp_on;
  logic             pipe_flush;
  logic             pipe_vld;
  logic             dly_vld;
  logic [PAY_W-1:0] pay;
  logic [PAY_W-1:0] dly_pay;
  logic [SEL_W-1:0] dly_sel;

  assign req_legal = sel_legal(int'(sel_req), NUM_SRC, PAT_EN);

  // A falling proc_ready overrides frame_start in every state.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_active;
    unique case (state)
      S_PROC: begin
        if (proc_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!proc_ready) begin
          state_nxt = S_PROC;
        end else if (frame_start) begin
          state_nxt = S_DISP;
          if (req_legal) sel_nxt = sel_req;
        end
      end
      S_DISP: begin
        if (!proc_ready) begin
          state_nxt = S_PROC;
        end else if (frame_start && req_legal) begin
          sel_nxt = sel_req;
        end
      end
      default: state_nxt = S_PROC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PROC;
      sel_active <= '0;
    end else begin
      state      <= state_nxt;
      sel_active <= sel_nxt;
    end
  end

  assign busy = (state != S_DISP);

  // The drop cycle itself already hands the buses back to the engine.
  assign disp_on    = (state == S_DISP) && proc_ready;
  assign pipe_flush = !disp_on;
  assign pipe_vld   = disp_on && vga.vga_addr_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_addr <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        buf_addr[i*ADDR_W +: ADDR_W] <= (disp_on && (int'(sel_active) == i))
                                        ? vga.vga_addr
                                        : proc_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef DISP_SRC_MUX_TEST_PATTERN_EN
  logic [PIX_W-1:0] pat_pix;
  logic [PIX_W-1:0] dly_pat;

  assign pat_pix = vga.vga_addr[PIX_W-1:0] ^ vga.vga_addr[ADDR_W-1 -: PIX_W];
  assign pay     = {pat_pix, sel_active};
  assign dly_pat = dly_pay[PAY_W-1 -: PIX_W];
`else
  assign pay = sel_active;
`endif

  assign dly_sel = dly_pay[SEL_W-1:0];

  // The select travels with each read so a mid-pipeline switch cannot mix sources.
  disp_lat_pipe #(
    .DEPTH (1 + RD_LAT),
    .W     (PAY_W)
  ) u_lat_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (pipe_flush),
    .sh_vld  (pipe_vld),
    .sh_dat  (pay),
    .dly_vld (dly_vld),
    .dly_dat (dly_pay)
  );

  always_comb begin
    vga.pix_out = BG_PIX;
    vga.pix_vld = 1'b0;
    if (dly_vld) begin
      vga.pix_vld = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (int'(dly_sel) == i) vga.pix_out = buf_dout[i*PIX_W +: PIX_W];
      end
`ifdef DISP_SRC_MUX_TEST_PATTERN_EN
      if (int'(dly_sel) == NUM_SRC) vga.pix_out = dly_pat;
`endif
    end
  end

endmodule
